// File: rtl/grad_spi_pkg.sv
// Shared constants, FSM state type and channel-index width helper for the
// gradient DAC SPI serialiser.
package grad_spi_pkg;

    localparam int BCAST_BIT = 24;
    localparam int CH_LSB    = 25;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FRAME_END,
        LDAC
    } state_t;

    // Channel-index field width; a single channel still gets one index bit.
    function automatic int calc_ch_w(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Bit timer: latches the divider at frame launch, counts cycles within each
// bit, generates the registered SPI clock and flags the last cycle of a bit.
module spi_bit_timer #(
    parameter int DIV_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_run,
    input  logic             i_last_bit,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_spi_clk,
    output logic             o_bit_done
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_ctr;
    logic             r_spi_clk;
    logic [DIV_W-1:0] w_ctr_nxt;

    assign w_ctr_nxt  = r_ctr + DIV_W'(1);
    assign o_bit_done = i_run && (r_ctr == r_div);
    assign o_spi_clk  = r_spi_clk;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_ctr     <= '0;
            r_spi_clk <= 1'b0;
        end else if (i_start) begin
            // A zero divider would give a one-cycle bit with no low phase.
            r_div     <= (i_div == '0) ? DIV_W'(1) : i_div;
            r_ctr     <= '0;
            r_spi_clk <= 1'b1;
        end else if (i_run) begin
            if (r_ctr == r_div) begin
                r_ctr     <= '0;
                r_spi_clk <= !i_last_bit;
            end else begin
                r_ctr     <= w_ctr_nxt;
                r_spi_clk <= (w_ctr_nxt <= (r_div >> 1));
            end
        end else begin
            r_ctr     <= '0;
            r_spi_clk <= 1'b0;
        end
    end

endmodule

// File: rtl/grad_spi_multi_iface.sv
// N-channel SPI serialiser for a gradient DAC bank: per-channel staging,
// broadcast launch with one-deep queue, optional LDAC pulse, data-lost flags.
module grad_spi_multi_iface
    import grad_spi_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WORD_W      = 24,
    parameter int DIV_W       = 6,
    parameter int LDAC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      data_i,
    input  logic             valid_i,
    input  logic [DIV_W-1:0] spi_clk_div_i,
    input  logic             ldac_en_i,
    output logic             spi_clk_o,
    output logic             syncn_o,
    output logic             ldacn_o,
    output logic [NCH-1:0]   sdo_o,
    output logic             busy_o,
    output logic             data_lost_o,
    output logic [NCH-1:0]   lost_mask_o
);

    localparam int CH_W = calc_ch_w(NCH);
    localparam int BI_W = $clog2(WORD_W);
    localparam int LC_W = (LDAC_CYCLES < 2) ? 1 : $clog2(LDAC_CYCLES);

    logic              r_in_valid;
    logic [WORD_W-1:0] r_in_word;
    logic              r_in_bcast;
    logic [CH_W-1:0]   r_in_ch;

    logic [WORD_W-1:0] r_staging [NCH];
    logic [WORD_W-1:0] r_shift   [NCH];
    logic [NCH-1:0]    r_present;
    logic [NCH-1:0]    r_lost_mask;
    logic              r_data_lost;
    logic              r_go;
    logic              r_pending;

    state_t            r_state;
    logic [BI_W-1:0]   r_bit_idx;
    logic [LC_W-1:0]   r_ldac_ctr;
    logic              r_syncn;
    logic              r_ldacn;
    logic              r_busy;
    logic [NCH-1:0]    r_sdo;

    logic w_write;
    logic w_bcast;
    logic w_launch;
    logic w_last_bit;
    logic w_bit_done;
    logic w_unused_data;

    assign w_unused_data = ^data_i;

    // NOTE: every always_comb output gets a value on every path, so no latch.
    always_comb begin
        w_write    = r_in_valid && (int'(r_in_ch) < NCH);
        w_bcast    = w_write && r_in_bcast;
        w_launch   = (r_state == IDLE) && (r_go || r_pending);
        w_last_bit = (r_bit_idx == BI_W'(WORD_W - 1));
    end

    spi_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_launch),
        .i_run      (r_state == SHIFT),
        .i_last_bit (w_last_bit),
        .i_div      (spi_clk_div_i),
        .o_spi_clk  (spi_clk_o),
        .o_bit_done (w_bit_done)
    );

    // Input register, staging writes and broadcast queueing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid  <= 1'b0;
            r_in_word   <= '0;
            r_in_bcast  <= 1'b0;
            r_in_ch     <= '0;
            r_present   <= '0;
            r_lost_mask <= '0;
            r_data_lost <= 1'b0;
            r_go        <= 1'b0;
            r_pending   <= 1'b0;
            // NOTE: the staging array is reset explicitly: after reset a
            // broadcast must transmit zeros on every unwritten channel.
            for (int i = 0; i < NCH; i++) r_staging[i] <= '0;
        end else begin
            r_in_valid <= valid_i;
            r_in_word  <= data_i[WORD_W-1:0];
            r_in_bcast <= data_i[BCAST_BIT];
            r_in_ch    <= data_i[CH_LSB +: CH_W];

            if (w_launch) begin
                r_go        <= 1'b0;
                r_pending   <= 1'b0;
                r_present   <= '0;
                r_lost_mask <= '0;
                r_data_lost <= 1'b0;
            end

            if (w_write) begin
                r_staging[r_in_ch] <= r_in_word;
                r_present[r_in_ch] <= 1'b1;
                // A word staged before this edge's launch is being sent, not lost.
                if (r_present[r_in_ch] && !w_launch) begin
                    r_lost_mask[r_in_ch] <= 1'b1;
                    r_data_lost          <= 1'b1;
                end
            end

            if (w_bcast) begin
                if ((r_state == IDLE) && !w_launch) begin
                    r_go <= 1'b1;
                end else if (r_pending && !w_launch) begin
                    r_data_lost <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    // Frame FSM with registered frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_idx  <= '0;
            r_ldac_ctr <= '0;
            r_syncn    <= 1'b1;
            r_ldacn    <= 1'b1;
            r_busy     <= 1'b0;
            r_sdo      <= '0;
            for (int i = 0; i < NCH; i++) r_shift[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state   <= SHIFT;
                        r_syncn   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_bit_idx <= '0;
                        for (int i = 0; i < NCH; i++) begin
                            r_shift[i] <= r_staging[i];
                            r_sdo[i]   <= r_staging[i][WORD_W-1];
                        end
                    end
                end
                SHIFT: begin
                    if (w_bit_done) begin
                        if (w_last_bit) begin
                            r_state <= FRAME_END;
                            r_syncn <= 1'b1;
                            r_sdo   <= '0;
                        end else begin
                            r_bit_idx <= r_bit_idx + BI_W'(1);
                            for (int i = 0; i < NCH; i++) begin
                                r_shift[i] <= r_shift[i] << 1;
                                r_sdo[i]   <= r_shift[i][WORD_W-2];
                            end
                        end
                    end
                end
                FRAME_END: begin
                    if (ldac_en_i) begin
                        r_state    <= LDAC;
                        r_ldacn    <= 1'b0;
                        r_ldac_ctr <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                LDAC: begin
                    if (r_ldac_ctr == LC_W'(LDAC_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_ldacn <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ldac_ctr <= r_ldac_ctr + LC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign syncn_o     = r_syncn;
    assign ldacn_o     = r_ldacn;
    assign busy_o      = r_busy;
    assign sdo_o       = r_sdo;
    assign data_lost_o = r_data_lost;
    assign lost_mask_o = r_lost_mask;

endmodule

// File: tb/tb_grad_spi_multi_iface.sv
// Directed self-checking bench for grad_spi_multi_iface (NCH=4, WORD_W=24):
// frame content/timing, LDAC pulse, loss flags, queueing, divider and reset.
module tb_grad_spi_multi_iface;

    localparam int NCH    = 4;
    localparam int WORD_W = 24;
    localparam int DIV_W  = 6;

    logic             clk;
    logic             rst;
    logic [31:0]      data_i;
    logic             valid_i;
    logic [DIV_W-1:0] spi_clk_div_i;
    logic             ldac_en_i;
    logic             spi_clk_o;
    logic             syncn_o;
    logic             ldacn_o;
    logic [NCH-1:0]   sdo_o;
    logic             busy_o;
    logic             data_lost_o;
    logic [NCH-1:0]   lost_mask_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WORD_W-1:0] exp_stage [NCH];
    logic [WORD_W-1:0] cap_words [NCH];
    int cap_len;
    int clk_errs;
    int sdo_errs;
    int frame_errs;

    grad_spi_multi_iface #(
        .NCH(NCH), .WORD_W(WORD_W), .DIV_W(DIV_W), .LDAC_CYCLES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .spi_clk_div_i (spi_clk_div_i),
        .ldac_en_i     (ldac_en_i),
        .spi_clk_o     (spi_clk_o),
        .syncn_o       (syncn_o),
        .ldacn_o       (ldacn_o),
        .sdo_o         (sdo_o),
        .busy_o        (busy_o),
        .data_lost_o   (data_lost_o),
        .lost_mask_o   (lost_mask_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one valid beat and updates the staging model.
    task automatic send(input int ch, input logic [WORD_W-1:0] word, input bit bcast);
        data_i               = '0;
        data_i[WORD_W-1:0]   = word;
        data_i[24]           = bcast;
        data_i[26:25]        = ch[1:0];
        valid_i              = 1'b1;
        exp_stage[ch]        = word;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic wait_syncn(input logic lvl, input string tag);
        int n;
        n = 0;
        while (syncn_o !== lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 500), 1);
    endtask

    // Samples one frame cycle by cycle; optionally changes the divider mid-frame.
    task automatic capture_frame(input int d, input int new_div);
        int c, bi, ph;
        wait_syncn(1'b0, "frame_start");
        for (int i = 0; i < NCH; i++) cap_words[i] = '0;
        clk_errs = 0; sdo_errs = 0; frame_errs = 0; c = 0;
        while (syncn_o === 1'b0 && c < 4000) begin
            bi = c / (d + 1);
            ph = c % (d + 1);
            if (bi < WORD_W) begin
                for (int i = 0; i < NCH; i++) begin
                    if (ph == 0) cap_words[i][WORD_W-1-bi] = sdo_o[i];
                    else if (sdo_o[i] !== cap_words[i][WORD_W-1-bi]) sdo_errs++;
                end
            end
            if (spi_clk_o !== ((ph <= d / 2) ? 1'b1 : 1'b0)) clk_errs++;
            if (ldacn_o !== 1'b1 || busy_o !== 1'b1) frame_errs++;
            if (c == 20) spi_clk_div_i = DIV_W'(new_div);
            c++;
            @(negedge clk);
        end
        cap_len = c;
    endtask

    task automatic check_frame(input string tag, input int d);
        check({tag, "_len"}, cap_len, WORD_W * (d + 1));
        for (int i = 0; i < NCH; i++)
            check($sformatf("%s_ch%0d", tag, i), cap_words[i], exp_stage[i]);
        check({tag, "_sclk_errs"}, clk_errs, 0);
        check({tag, "_sdo_stable_errs"}, sdo_errs, 0);
        check({tag, "_ldacn_busy_errs"}, frame_errs, 0);
        check({tag, "_end_spi_clk"}, spi_clk_o, 0);
        check({tag, "_end_sdo"}, sdo_o, 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; valid_i = 1'b0; data_i = '0;
        spi_clk_div_i = 6'd3; ldac_en_i = 1'b0;
        for (int i = 0; i < NCH; i++) exp_stage[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_spi_clk", spi_clk_o, 0);
        check("rst_syncn", syncn_o, 1);
        check("rst_ldacn", ldacn_o, 1);
        check("rst_sdo", sdo_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data_lost", data_lost_o, 0);
        check("rst_lost_mask", lost_mask_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: four words, broadcast on the last, no LDAC.
        send(0, 24'hA5A5A5, 0);
        send(1, 24'h000001, 0);
        send(2, 24'h800000, 0);
        send(3, 24'hFFFFFF, 1);
        capture_frame(3, 3);
        check_frame("t1", 3);
        check("t1_fe_ldacn", ldacn_o, 1);
        check("t1_fe_busy", busy_o, 1);
        @(negedge clk);
        check("t1_idle_busy", busy_o, 0);
        check("t1_idle_ldacn", ldacn_o, 1);

        // 2: same stimulus with the LDAC pulse enabled.
        ldac_en_i = 1'b1;
        send(0, 24'hA5A5A5, 0);
        send(1, 24'h000001, 0);
        send(2, 24'h800000, 0);
        send(3, 24'hFFFFFF, 1);
        capture_frame(3, 3);
        check_frame("t2", 3);
        check("t2_fe_ldacn", ldacn_o, 1);
        @(negedge clk);
        check("t2_ldac1", ldacn_o, 0);
        @(negedge clk);
        check("t2_ldac2", ldacn_o, 0);
        check("t2_ldac2_busy", busy_o, 1);
        @(negedge clk);
        check("t2_after_ldacn", ldacn_o, 1);
        check("t2_after_busy", busy_o, 0);
        ldac_en_i = 1'b0;

        // 3: overwrite ch1 without broadcast, then launch.
        send(1, 24'h123456, 0);
        send(1, 24'h654321, 0);
        @(negedge clk);
        check("t3_lost_mask", lost_mask_o, 4'b0010);
        check("t3_data_lost", data_lost_o, 1);
        send(2, 24'h0F0F0F, 1);
        capture_frame(3, 3);
        check_frame("t3", 3);
        check("t3_cleared_mask", lost_mask_o, 0);
        check("t3_cleared_lost", data_lost_o, 0);
        @(negedge clk);

        // 4: queued broadcast plus a dropped second one.
        send(0, 24'h111111, 1);
        wait_syncn(1'b0, "t4_a_start");
        repeat (8) @(negedge clk);
        send(0, 24'h222222, 1);
        @(negedge clk);
        check("t4_q1_lost", data_lost_o, 0);
        check("t4_q1_busy", busy_o, 1);
        send(1, 24'h333333, 1);
        @(negedge clk);
        check("t4_q2_lost", data_lost_o, 1);
        check("t4_q2_mask", lost_mask_o, 0);
        wait_syncn(1'b1, "t4_a_end");
        check("t4_fe_busy", busy_o, 1);
        @(negedge clk);
        check("t4_idle_busy", busy_o, 0);
        check("t4_idle_syncn", syncn_o, 1);
        @(negedge clk);
        check("t4_relaunch_syncn", syncn_o, 0);
        check("t4_relaunch_busy", busy_o, 1);
        check("t4_relaunch_lost", data_lost_o, 0);
        capture_frame(3, 3);
        check_frame("t4", 3);

        // 5: divider change mid-frame, then the slower and fastest frames.
        spi_clk_div_i = 6'd3;
        send(0, 24'hC3C3C3, 1);
        capture_frame(3, 7);
        check_frame("t5_d3", 3);
        send(1, 24'h5A5A5A, 1);
        capture_frame(7, 7);
        check_frame("t5_d7", 7);
        spi_clk_div_i = 6'd0;
        send(2, 24'h00FF00, 1);
        capture_frame(1, 0);
        check_frame("t5_d0", 1);

        // 6: reset at bit 10, then a broadcast of cleared staging.
        @(negedge clk);
        spi_clk_div_i = 6'd3;
        send(0, 24'h777777, 1);
        wait_syncn(1'b0, "t6_start");
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_syncn", syncn_o, 1);
        check("t6_spi_clk", spi_clk_o, 0);
        check("t6_sdo", sdo_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_ldacn", ldacn_o, 1);
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) exp_stage[i] = '0;
        @(negedge clk);
        check("t6_idle_busy", busy_o, 0);
        send(3, 24'h000000, 1);
        capture_frame(3, 3);
        check_frame("t6", 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
